// File: rtl/spi_rx_frame_assembler.sv
// Receive-side framer: parses length-prefixed frames from SPI byte strobes,
// verifies the additive checksum, buffers the payload and streams it out.
module spi_rx_frame_assembler #(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [7:0] frame_len,
    output logic       busy,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [2:0] state_dbg
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    localparam logic [1:0] ERR_LEN   = 2'b01;
    localparam logic [1:0] ERR_SUM   = 2'b10;
    localparam logic [1:0] ERR_TRUNC = 2'b11;

    // Handshake: a byte moves when out_valid & out_ready at a rising edge;
    // out_valid is registered and out_data/out_last hold until that pop.

    logic [2:0] state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rd_ptr_q, rd_ptr_d;
    logic [7:0] frame_len_q, frame_len_d;
    logic [1:0] err_code_q, err_code_d;
    logic       frame_ok_q, frame_ok_d;
    logic       frame_err_q, frame_err_d;
    logic       out_valid_q, out_valid_d;
    logic       busy_q, busy_d;
    logic       mem_we;
    logic [7:0] mem_q [MAX_LEN];

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        frame_len_d = frame_len_q;
        err_code_d  = err_code_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_LEN;
                    sum_d   = 8'd0;
                    cnt_d   = 8'd0;
                end
            end
            S_LEN, S_PAYLOAD, S_CHECK: begin
                if (frame_start) begin
                    // Abort: restart on the new burst, any same-cycle byte is dropped.
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TRUNC;
                    state_d     = S_LEN;
                    sum_d       = 8'd0;
                    cnt_d       = 8'd0;
                end else if (rx_valid) begin
                    if (state_q == S_LEN) begin
                        if (rx_byte == 8'd0 || rx_byte > MAX_LEN_B) begin
                            frame_err_d = 1'b1;
                            err_code_d  = ERR_LEN;
                            state_d     = S_IDLE;
                        end else begin
                            len_d   = rx_byte;
                            sum_d   = rx_byte;
                            cnt_d   = 8'd0;
                            state_d = S_PAYLOAD;
                        end
                    end else if (state_q == S_PAYLOAD) begin
                        mem_we = 1'b1;
                        sum_d  = sum_q + rx_byte;
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q == len_q - 8'd1) begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        if (rx_byte == sum_q) begin
                            frame_ok_d  = 1'b1;
                            frame_len_d = len_q;
                            rd_ptr_d    = 8'd0;
                            state_d     = S_DRAIN;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = ERR_SUM;
                            state_d     = S_IDLE;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (frame_start || rx_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TRUNC;
                end
                if (out_valid_q && out_ready) begin
                    if (rd_ptr_q == len_q - 8'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        out_valid_d = (state_d == S_DRAIN);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            len_q       <= 8'd0;
            sum_q       <= 8'd0;
            cnt_q       <= 8'd0;
            rd_ptr_q    <= 8'd0;
            frame_len_q <= 8'd0;
            err_code_q  <= 2'b00;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_len_q <= frame_len_d;
            err_code_q  <= err_code_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Payload buffer is not reset; stale contents are masked by out_valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[cnt_q[AW-1:0]] <= rx_byte;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign out_last  = out_valid_q && (rd_ptr_q == len_q - 8'd1);
    assign frame_len = frame_len_q;
    assign busy      = busy_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_rx_frame_assembler.sv
// Directed bench for spi_rx_frame_assembler: hand-computed frames, an
// expected-byte queue for drained payload, and a single checking task.
module tb_spi_rx_frame_assembler;

    localparam int MAX_LEN = 64;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic [7:0] frame_len;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    spi_rx_frame_assembler #(.MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_len  (frame_len),
        .busy       (busy),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        step();
        rx_valid = 1'b0;
    endtask

    // Drains one frame against exp_q; toggle selects out_ready pattern 1,0,0,1,0,0...
    task automatic drain(input bit toggle, output int pops);
        int cyc;
        bit done;
        bit stalled;
        logic [7:0] held;
        logic [7:0] e;
        cyc = 0;
        done = 1'b0;
        stalled = 1'b0;
        held = 8'h00;
        pops = 0;
        while (!done && cyc < 1000) begin
            out_ready = toggle ? (cyc % 3 == 0) : 1'b1;
            if (out_valid) begin
                if (stalled) check_eq("stall_hold", 32'(out_data), 32'(held));
                if (out_ready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    check_eq("drain_data", 32'(out_data), 32'(e));
                    check_eq("drain_last", 32'(out_last), 32'(exp_q.size() == 0));
                    pops++;
                    stalled = 1'b0;
                    if (out_last) done = 1'b1;
                end else begin
                    held = out_data;
                    stalled = 1'b1;
                end
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check_eq("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        int pops;
        logic [7:0] sum;
        logic [7:0] b;

        rst = 1'b0;
        frame_start = 1'b0;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        out_ready = 1'b0;
        step();
        step();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame_len", 32'(frame_len), 32'd0);
        check_eq("rst_err_code", 32'(err_code), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b1;
        step();

        // good frame 03 11 22 33 69
        pulse_start();
        check_eq("start_busy", 32'(busy), 32'd1);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        out_ready = 1'b1;
        send_byte(8'h69);
        check_eq("good_ok", 32'(frame_ok), 32'd1);
        check_eq("good_err", 32'(frame_err), 32'd0);
        check_eq("good_valid", 32'(out_valid), 32'd1);
        check_eq("good_len", 32'(frame_len), 32'd3);
        check_eq("good_d0", 32'(out_data), 32'h11);
        check_eq("good_l0", 32'(out_last), 32'd0);
        step();
        check_eq("good_ok_pulse", 32'(frame_ok), 32'd0);
        check_eq("good_d1", 32'(out_data), 32'h22);
        check_eq("good_l1", 32'(out_last), 32'd0);
        step();
        check_eq("good_d2", 32'(out_data), 32'h33);
        check_eq("good_l2", 32'(out_last), 32'd1);
        step();
        check_eq("good_end_valid", 32'(out_valid), 32'd0);
        check_eq("good_end_busy", 32'(busy), 32'd0);
        check_eq("good_len_hold", 32'(frame_len), 32'd3);
        out_ready = 1'b0;

        // checksum error 02 AA 55 00, expected checksum 01
        pulse_start();
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_byte(8'h00);
        check_eq("sum_err", 32'(frame_err), 32'd1);
        check_eq("sum_ok", 32'(frame_ok), 32'd0);
        check_eq("sum_code", 32'(err_code), 32'd2);
        check_eq("sum_valid", 32'(out_valid), 32'd0);
        check_eq("sum_busy", 32'(busy), 32'd0);
        step();
        check_eq("sum_err_pulse", 32'(frame_err), 32'd0);
        check_eq("sum_code_hold", 32'(err_code), 32'd2);
        check_eq("sum_valid2", 32'(out_valid), 32'd0);

        // length bounds
        pulse_start();
        send_byte(8'h00);
        check_eq("len0_err", 32'(frame_err), 32'd1);
        check_eq("len0_code", 32'(err_code), 32'd1);
        check_eq("len0_busy", 32'(busy), 32'd0);
        step();
        pulse_start();
        send_byte(8'(MAX_LEN + 1));
        check_eq("lenmax1_err", 32'(frame_err), 32'd1);
        check_eq("lenmax1_code", 32'(err_code), 32'd1);
        check_eq("lenmax1_busy", 32'(busy), 32'd0);
        step();

        // L = MAX_LEN, checksum wraps
        pulse_start();
        send_byte(8'(MAX_LEN));
        sum = 8'(MAX_LEN);
        for (int i = 0; i < MAX_LEN; i++) begin
            b = 8'(i * 5 + 200);
            sum = sum + b;
            exp_q.push_back(b);
            send_byte(b);
        end
        send_byte(sum);
        check_eq("max_ok", 32'(frame_ok), 32'd1);
        check_eq("max_len", 32'(frame_len), 32'(MAX_LEN));
        drain(1'b0, pops);
        check_eq("max_pops", 32'(pops), 32'(MAX_LEN));
        check_eq("max_busy", 32'(busy), 32'd0);

        // backpressure, 4-byte frame, checksum 04+0A+0B+0C+0D = 32
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h0C);
        send_byte(8'h0D);
        send_byte(8'h32);
        check_eq("bp_ok", 32'(frame_ok), 32'd1);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0B);
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'h0D);
        drain(1'b1, pops);
        check_eq("bp_pops", 32'(pops), 32'd4);
        check_eq("bp_busy", 32'(busy), 32'd0);

        // abort after 2 of 5 payload bytes, with a same-cycle byte to discard
        pulse_start();
        send_byte(8'h05);
        send_byte(8'hA1);
        send_byte(8'hA2);
        frame_start = 1'b1;
        rx_valid = 1'b1;
        rx_byte = 8'hFF;
        step();
        frame_start = 1'b0;
        rx_valid = 1'b0;
        check_eq("abort_err", 32'(frame_err), 32'd1);
        check_eq("abort_code", 32'(err_code), 32'd3);
        check_eq("abort_busy", 32'(busy), 32'd1);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h32);
        check_eq("abort_new_ok", 32'(frame_ok), 32'd1);
        check_eq("abort_new_len", 32'(frame_len), 32'd2);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        drain(1'b0, pops);
        check_eq("abort_pops", 32'(pops), 32'd2);

        // set err_code to 01 so the overrun code change is visible
        pulse_start();
        send_byte(8'h00);
        check_eq("pre_ovr_code", 32'(err_code), 32'd1);

        // overrun during drain: frame 02 5A A5 checksum 01
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_byte(8'h01);
        check_eq("ovr_ok", 32'(frame_ok), 32'd1);
        send_byte(8'h77);
        check_eq("ovr_rx_err", 32'(frame_err), 32'd1);
        check_eq("ovr_rx_code", 32'(err_code), 32'd3);
        check_eq("ovr_valid", 32'(out_valid), 32'd1);
        check_eq("ovr_data", 32'(out_data), 32'h5A);
        pulse_start();
        check_eq("ovr_fs_err", 32'(frame_err), 32'd1);
        check_eq("ovr_fs_data", 32'(out_data), 32'h5A);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hA5);
        drain(1'b0, pops);
        check_eq("ovr_pops", 32'(pops), 32'd2);
        check_eq("ovr_len", 32'(frame_len), 32'd2);
        check_eq("ovr_busy", 32'(busy), 32'd0);

        // reset after one pop: frame 03 01 02 03 checksum 09
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        out_ready = 1'b1;
        send_byte(8'h09);
        check_eq("rd_d0", 32'(out_data), 32'h01);
        step();
        check_eq("rd_d1", 32'(out_data), 32'h02);
        out_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_len", 32'(frame_len), 32'd0);
        check_eq("arst_code", 32'(err_code), 32'd0);
        step();
        rst = 1'b1;
        send_byte(8'h03);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        send_byte(8'hAA);
        check_eq("post_rst_err", 32'(frame_err), 32'd0);
        check_eq("post_rst_ok", 32'(frame_ok), 32'd0);
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h42);
        send_byte(8'h43);
        check_eq("post_rst_frame_ok", 32'(frame_ok), 32'd1);
        exp_q.push_back(8'h42);
        drain(1'b0, pops);
        check_eq("post_rst_pops", 32'(pops), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_rx_frame_assembler.md
# spi_rx_frame_assembler

Receive-side framing stage directly downstream of `spi_master` in the transceiver path. It consumes the byte strobes produced during a radio RX-FIFO read burst, parses a length-prefixed frame, verifies an 8-bit additive checksum and buffers the payload. It then presents the payload to the downlink consumer over a valid/ready stream. Frames that are malformed or interrupted are dropped and flagged.

## Interface
- `MAX_LEN`, 64: maximum payload bytes per frame, 1..255; sizes the internal buffer.
- `clk`  in  1  system clock (26 MHz transceiver domain)
- `rst`  in  1  asynchronous, active-low reset
- `frame_start`  in  1  one-cycle pulse from the mode controller marking the start of an RX burst
- `rx_valid`  in  1  one-cycle strobe from `spi_master` `new_data`: `rx_byte` is valid
- `rx_byte`  in  8  received byte (`spi_master` `data_out`)
- `out_ready`  in  1  consumer accepts `out_data` this cycle
- `out_valid`  out  1  `out_data` holds a valid payload byte
- `out_data`  out  8  payload byte
- `out_last`  out  1  current `out_data` is the final payload byte
- `frame_len`  out  8  length of the frame being presented; holds its value until the next accepted frame
- `busy`  out  1  state is not IDLE
- `frame_ok`  out  1  one-cycle pulse when a frame passes its checksum
- `frame_err`  out  1  one-cycle pulse when a frame is dropped
- `err_code`  out  2  cause of the most recent error; holds its value until the next error. 01 bad length, 10 checksum mismatch, 11 truncated or overrun.

## Operation
- Wire format: a length byte L, then L payload bytes, then checksum byte C. C = (L + Σpayload) mod 256.
- **IDLE**
  - `rx_valid` is ignored.
  - `frame_start` → LEN, and clears the running sum and byte count.
- **LEN**, on `rx_valid`:
  - If L==0 or L>MAX_LEN: pulse `frame_err`, set `err_code`=01, go to IDLE.
  - Otherwise: latch L, set sum=L, count=0, go to PAYLOAD.
- **PAYLOAD**, on `rx_valid`:
  - Write `mem[count]`, add the byte to sum (8-bit wrap), increment count.
  - The write with count==L-1 moves to CHECK.
- **CHECK**, on `rx_valid`:
  - If byte==sum: pulse `frame_ok`, update `frame_len`=L, set rd_ptr=0, go to DRAIN.
  - Otherwise: pulse `frame_err`, set `err_code`=10, go to IDLE.
- **DRAIN**
  - `out_valid`=1. `out_data`=`mem[rd_ptr]`. `out_last`=(rd_ptr==L-1).
  - A pop occurs when `out_valid`&`out_ready`; each pop increments rd_ptr.
  - The pop with `out_last` high returns to IDLE.
  - `out_valid` never depends combinationally on `out_ready`.
  - `out_data` and `out_last` are stable while `out_valid`&!`out_ready`.
- **Abort:** `frame_start` in LEN, PAYLOAD or CHECK:
  - pulse `frame_err` with `err_code`=11;
  - restart at LEN with sum and count cleared;
  - discard any `rx_valid` byte in the same cycle.
- **Overrun:** in DRAIN, `frame_start` or `rx_valid` is ignored (data dropped). Either one pulses `frame_err` with `err_code`=11. The frame being presented is unaffected.
- **Simultaneous events:**
  - In IDLE, `frame_start` together with `rx_valid` starts the frame and discards the byte.
  - `frame_ok` and `frame_err` are never high in the same cycle.
- **Reset (`rst` low, any time):**
  - state→IDLE; counters, sum, `frame_len` and `err_code` → 0.
  - All outputs → 0 immediately, including `out_valid` mid-drain.
  - Buffer contents need not be cleared.

## Timing
- All outputs are registered except `out_data` and `out_last`. Those two are decoded from the registered rd_ptr and buffer, with no input-to-output combinational path.
- `frame_start` at cycle T → `busy`=1 at T+1.
- Checksum `rx_valid` at cycle T → `frame_ok`=1 and `out_valid`=1 at T+1.
- Error detected on an input at cycle T → `frame_err` and `err_code` visible at T+1. `busy` falls at T+1.
- Accepts back-to-back `rx_valid` every cycle.
- Drain throughput is 1 byte per cycle with `out_ready` held high: L bytes in L cycles. `busy` falls the cycle after the last pop.

## Test plan
- Good frame: `frame_start`, then bytes 03 11 22 33 69 with `out_ready`=1.
  - `frame_ok` 1 cycle after 69; `frame_len`=3.
  - Stream 11, 22, 33 on consecutive cycles, `out_last` on 33, then IDLE.
- Checksum error: bytes 02 AA 55 00 (expected sum 01).
  - `frame_err`, `err_code`=10, `out_valid` never asserted.
- Length bounds:
  - L=00 → `err_code`=01.
  - L=MAX_LEN+1 → `err_code`=01.
  - L=MAX_LEN with a correct checksum → all MAX_LEN bytes drained in order; the checksum wraps mod 256.
- Backpressure: good 4-byte frame with `out_ready` toggling 1,0,0,1,…
  - `out_data` holds during stalls; exactly 4 pops; `out_last` only on the 4th.
- Abort and overrun:
  - `frame_start` after 2 of 5 payload bytes → `err_code`=11, then a new good frame is accepted.
  - `rx_valid` during DRAIN → `err_code`=11 and the drained data is unchanged.
- Reset mid-drain: assert `rst` low after 1 pop.
  - `out_valid`, `busy` and `frame_len` go to 0 asynchronously.
  - After release, the block is IDLE and ignores `rx_valid` until `frame_start`.
